// File: rtl/matvec_acc_stream_if.sv
// Streaming bundle for matvec_acc_stream: tile input side (s_*) and result side (m_*).
// master drives tiles and consumes results; slave is the multiplier itself.
interface matvec_acc_stream_if #(
    parameter int R         = 2,
    parameter int C         = 2,
    parameter int W_X       = 3,
    parameter int W_K       = 3,
    parameter int MAX_TILES = 4
);
    localparam int DEPTH = $clog2(C);
    localparam int W_P   = W_X + W_K + DEPTH;
    localparam int W_Y   = W_P + $clog2(MAX_TILES);

    logic                 s_valid;
    logic                 s_ready;
    logic                 s_last;
    logic                 s_relu;
    logic [R*C*W_K-1:0]   s_k;
    logic [C*W_X-1:0]     s_x;
    logic                 m_valid;
    logic                 m_ready;
    logic [R*W_Y-1:0]     m_y;
    logic                 m_ovf;

    modport master (
        output s_valid, s_last, s_relu, s_k, s_x, m_ready,
        input  s_ready, m_valid, m_y, m_ovf
    );

    modport slave (
        input  s_valid, s_last, s_relu, s_k, s_x, m_ready,
        output s_ready, m_valid, m_y, m_ovf
    );
endinterface

// File: rtl/matvec_acc_stream.sv
// Pipelined signed matrix-vector multiply-accumulate over column tiles.
// Stages: input capture, products, DEPTH adder-tree levels, per-row accumulator/output.
module matvec_acc_stream #(
    parameter int R         = 2,
    parameter int C         = 2,
    parameter int W_X       = 3,
    parameter int W_K       = 3,
    parameter int MAX_TILES = 4
) (
    input  logic clk,
    input  logic rstn,
    matvec_acc_stream_if.slave bus
);
    localparam int DEPTH = $clog2(C);
    localparam int CP    = 1 << DEPTH;
    localparam int L     = DEPTH + 1;
    localparam int W_PR  = W_X + W_K;
    localparam int W_P   = W_PR + DEPTH;
    localparam int W_Y   = W_P + $clog2(MAX_TILES);
    localparam int CW    = (MAX_TILES > 1) ? $clog2(MAX_TILES) : 1;

    logic                   en;
    logic                   accept;
    logic                   at_max;
    logic                   close;

    logic [CW-1:0]          cnt_q, cnt_d;

    logic                   iv_q, iv_d, il_q, il_d, ir_q, ir_d, io_q, io_d;
    logic signed [W_K-1:0]  ik_q [R][CP];
    logic signed [W_K-1:0]  ik_d [R][CP];
    logic signed [W_X-1:0]  ix_q [CP];
    logic signed [W_X-1:0]  ix_d [CP];

    // level 0 holds products, level DEPTH holds the finished tree sum in lane 0
    logic signed [W_P-1:0]  tr_q [L][R][CP];
    logic signed [W_P-1:0]  tr_d [L][R][CP];
    logic [L-1:0]           tv_q, tv_d, tl_q, tl_d, trl_q, trl_d, to_q, to_d;

    logic signed [W_Y-1:0]  acc_q [R];
    logic signed [W_Y-1:0]  acc_d [R];
    logic signed [W_Y-1:0]  y_q [R];
    logic signed [W_Y-1:0]  y_d [R];
    logic                   mv_q, mv_d, movf_q, movf_d;

    assign en     = !mv_q || bus.m_ready;
    assign accept = bus.s_valid && rstn && en;
    assign at_max = (cnt_q == CW'(MAX_TILES - 1));
    assign close  = bus.s_last || at_max;

    assign bus.s_ready = rstn && en;
    assign bus.m_valid = mv_q;
    assign bus.m_ovf   = movf_q;

    always_comb begin
        bus.m_y = '0;
        for (int r = 0; r < R; r++) begin
            bus.m_y[r*W_Y +: W_Y] = y_q[r];
        end
    end

    always_comb begin
        logic signed [W_PR-1:0] prod;
        logic signed [W_Y-1:0]  sum;
        prod   = '0;
        sum    = '0;
        cnt_d  = cnt_q;
        iv_d   = iv_q;
        il_d   = il_q;
        ir_d   = ir_q;
        io_d   = io_q;
        ik_d   = ik_q;
        ix_d   = ix_q;
        tr_d   = tr_q;
        tv_d   = tv_q;
        tl_d   = tl_q;
        trl_d  = trl_q;
        to_d   = to_q;
        acc_d  = acc_q;
        y_d    = y_q;
        mv_d   = mv_q;
        movf_d = movf_q;

        if (accept) begin
            cnt_d = close ? '0 : cnt_q + CW'(1);
        end

        if (en) begin
            iv_d = accept;
            il_d = close;
            ir_d = bus.s_relu;
            io_d = !bus.s_last && at_max;
            if (accept) begin
                // pad lanes (c >= C) are never loaded and stay zero from reset
                for (int c = 0; c < C; c++) begin
                    ix_d[c] = bus.s_x[c*W_X +: W_X];
                    for (int r = 0; r < R; r++) begin
                        ik_d[r][c] = bus.s_k[(r*C + c)*W_K +: W_K];
                    end
                end
            end

            tv_d[0]  = iv_q;
            tl_d[0]  = il_q;
            trl_d[0] = ir_q;
            to_d[0]  = io_q;
            for (int r = 0; r < R; r++) begin
                for (int c = 0; c < C; c++) begin
                    prod          = ik_q[r][c] * ix_q[c];
                    tr_d[0][r][c] = W_P'(prod);
                end
            end

            for (int lvl = 1; lvl <= DEPTH; lvl++) begin
                tv_d[lvl]  = tv_q[lvl-1];
                tl_d[lvl]  = tl_q[lvl-1];
                trl_d[lvl] = trl_q[lvl-1];
                to_d[lvl]  = to_q[lvl-1];
                for (int r = 0; r < R; r++) begin
                    for (int i = 0; i < (CP >> lvl); i++) begin
                        tr_d[lvl][r][i] = tr_q[lvl-1][r][2*i] + tr_q[lvl-1][r][2*i+1];
                    end
                end
            end

            mv_d = tv_q[DEPTH] && tl_q[DEPTH];
            if (tv_q[DEPTH]) begin
                for (int r = 0; r < R; r++) begin
                    sum = acc_q[r] + W_Y'(tr_q[DEPTH][r][0]);
                    if (tl_q[DEPTH]) begin
                        y_d[r]   = (trl_q[DEPTH] && sum[W_Y-1]) ? '0 : sum;
                        acc_d[r] = '0;
                    end else begin
                        acc_d[r] = sum;
                    end
                end
                if (tl_q[DEPTH]) begin
                    movf_d = to_q[DEPTH];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q  <= '0;
            iv_q   <= 1'b0;
            il_q   <= 1'b0;
            ir_q   <= 1'b0;
            io_q   <= 1'b0;
            ik_q   <= '{default: '0};
            ix_q   <= '{default: '0};
            tr_q   <= '{default: '0};
            tv_q   <= '0;
            tl_q   <= '0;
            trl_q  <= '0;
            to_q   <= '0;
            acc_q  <= '{default: '0};
            y_q    <= '{default: '0};
            mv_q   <= 1'b0;
            movf_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            iv_q   <= iv_d;
            il_q   <= il_d;
            ir_q   <= ir_d;
            io_q   <= io_d;
            ik_q   <= ik_d;
            ix_q   <= ix_d;
            tr_q   <= tr_d;
            tv_q   <= tv_d;
            tl_q   <= tl_d;
            trl_q  <= trl_d;
            to_q   <= to_d;
            acc_q  <= acc_d;
            y_q    <= y_d;
            mv_q   <= mv_d;
            movf_q <= movf_d;
        end
    end
endmodule

// File: tb/tb_matvec_acc_stream.sv
// Bench for matvec_acc_stream: directed vector table, corner sequences, random traffic vs a dot-product model.
module tb_matvec_acc_stream;
    localparam int R   = 2;
    localparam int C   = 2;
    localparam int W_X = 3;
    localparam int W_K = 3;
    localparam int MT  = 4;
    localparam int W_Y = 9;
    localparam int LAT = 3;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    matvec_acc_stream_if #(.R(R), .C(C), .W_X(W_X), .W_K(W_K), .MAX_TILES(MT)) bus ();

    matvec_acc_stream #(.R(R), .C(C), .W_X(W_X), .W_K(W_K), .MAX_TILES(MT)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    typedef struct {
        int k00, k01, k10, k11, x0, x1;
        bit last, relu, out;
        int y0, y1;
        bit ovf;
    } vec_t;

    typedef struct {
        int y0, y1;
        bit ovf;
    } exp_t;

    int   checks    = 0;
    int   errors    = 0;
    int   delivered = 0;
    exp_t exp_q[$];
    int   acc_m[R];
    int   tiles_m   = 0;
    vec_t tbl[$];

    task automatic check(string name, int act, int req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic int sx3(logic [2:0] v);
        return int'($signed(v));
    endfunction

    function automatic int in_k(int r, int c);
        logic [R*C*W_K-1:0] v;
        v = bus.s_k;
        return sx3(v[(r*C + c)*W_K +: W_K]);
    endfunction

    function automatic int in_x(int c);
        logic [C*W_X-1:0] v;
        v = bus.s_x;
        return sx3(v[c*W_X +: W_X]);
    endfunction

    function automatic int out_y(int r);
        logic [R*W_Y-1:0] v;
        v = bus.m_y;
        return int'($signed(v[r*W_Y +: W_Y]));
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // reference: running dot product per row, result closes on last or on the MT-th tile
    initial begin : monitor
        bit   hold_prev = 1'b0;
        int   prev_y    = 0;
        int   prev_ovf  = 0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rstn) begin
                exp_q.delete();
                for (int r = 0; r < R; r++) acc_m[r] = 0;
                tiles_m   = 0;
                hold_prev = 1'b0;
            end else begin
                check("s_ready_rule", int'(bus.s_ready), int'(!bus.m_valid || bus.m_ready));
                if (hold_prev) begin
                    check("hold_m_valid", int'(bus.m_valid), 1);
                    check("hold_m_y", int'(bus.m_y), prev_y);
                    check("hold_m_ovf", int'(bus.m_ovf), prev_ovf);
                end
                hold_prev = bus.m_valid && !bus.m_ready;
                prev_y    = int'(bus.m_y);
                prev_ovf  = int'(bus.m_ovf);
                if (bus.m_valid && bus.m_ready) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_result", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        check("sb_y0", out_y(0), e.y0);
                        check("sb_y1", out_y(1), e.y1);
                        check("sb_ovf", int'(bus.m_ovf), int'(e.ovf));
                    end
                    delivered++;
                end
                if (bus.s_valid && bus.s_ready) begin
                    for (int r = 0; r < R; r++) begin
                        for (int c = 0; c < C; c++) acc_m[r] += in_k(r, c) * in_x(c);
                    end
                    tiles_m++;
                    if (bus.s_last || tiles_m == MT) begin
                        e.y0  = (bus.s_relu && acc_m[0] < 0) ? 0 : acc_m[0];
                        e.y1  = (bus.s_relu && acc_m[1] < 0) ? 0 : acc_m[1];
                        e.ovf = !bus.s_last;
                        exp_q.push_back(e);
                        for (int r = 0; r < R; r++) acc_m[r] = 0;
                        tiles_m = 0;
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic drive_beat(int k00, int k01, int k10, int k11, int x0, int x1, bit last, bit relu);
        bus.s_k     = {3'(k11), 3'(k10), 3'(k01), 3'(k00)};
        bus.s_x     = {3'(x1), 3'(x0)};
        bus.s_last  = last;
        bus.s_relu  = relu;
        bus.s_valid = 1'b1;
    endtask

    task automatic send_beat(int k00, int k01, int k10, int k11, int x0, int x1, bit last, bit relu);
        int n  = 0;
        bit ok = 1'b0;
        drive_beat(k00, k01, k10, k11, x0, x1, last, relu);
        do begin
            @(negedge clk);
            ok = bus.s_ready;
            tick();
            n++;
        end while (!ok && n < 50);
        if (!ok) check("accept_timeout", 0, 1);
        bus.s_valid = 1'b0;
    endtask

    task automatic wait_result(output int n);
        n = 0;
        while (!bus.m_valid && n < 20) begin
            tick();
            n++;
        end
    endtask

    initial begin : main
        int   n;
        int   start;
        int   sent;
        int   cyc;
        bit   need_new;
        bit   pat[4];
        vec_t v;

        bus.s_valid = 1'b0;
        bus.s_last  = 1'b0;
        bus.s_relu  = 1'b0;
        bus.s_k     = '0;
        bus.s_x     = '0;
        bus.m_ready = 1'b1;

        #12;
        check("rst_m_valid", int'(bus.m_valid), 0);
        check("rst_s_ready", int'(bus.s_ready), 0);
        check("rst_m_y", int'(bus.m_y), 0);
        check("rst_m_ovf", int'(bus.m_ovf), 0);
        tick();
        rstn = 1'b1;
        #1;
        check("post_rst_s_ready", int'(bus.s_ready), 1);
        tick();

        //                k00 k01 k10 k11  x0  x1 last relu out  y0   y1  ovf
        tbl.push_back('{  1,  2,  3, -4,  2, -1, 1'b1, 1'b0, 1'b1,   0,  10, 1'b0});
        tbl.push_back('{  1,  1,  1,  1,  3,  3, 1'b0, 1'b0, 1'b0,   0,   0, 1'b0});
        tbl.push_back('{  1,  1,  1,  1, -4, -4, 1'b1, 1'b0, 1'b1,  -2,  -2, 1'b0});
        tbl.push_back('{  1,  0,  0,  1,  3, -2, 1'b1, 1'b0, 1'b1,   3,  -2, 1'b0});
        tbl.push_back('{ -4, -4,  3,  3,  3,  3, 1'b1, 1'b1, 1'b1,   0,  18, 1'b0});
        tbl.push_back('{ -4, -4,  3,  3,  3,  3, 1'b1, 1'b0, 1'b1, -24,  18, 1'b0});
        for (int i = 0; i < 3; i++)
            tbl.push_back('{1, 1, 1, 1, 1, 1, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0});
        tbl.push_back('{  1,  1,  1,  1,  1,  1, 1'b0, 1'b1, 1'b1,   8,   8, 1'b1});
        tbl.push_back('{  1,  1,  1,  1,  1,  1, 1'b1, 1'b0, 1'b1,   2,   2, 1'b0});
        for (int i = 0; i < 3; i++)
            tbl.push_back('{-4, -4, -4, -4, -4, -4, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0});
        tbl.push_back('{ -4, -4, -4, -4, -4, -4, 1'b1, 1'b1, 1'b1, 128, 128, 1'b0});
        tbl.push_back('{ -4, -4,  3, -4,  3, -4, 1'b1, 1'b0, 1'b1,   4, 25, 1'b0});

        foreach (tbl[i]) begin
            v = tbl[i];
            send_beat(v.k00, v.k01, v.k10, v.k11, v.x0, v.x1, v.last, v.relu);
            if (v.out) begin
                wait_result(n);
                check($sformatf("tbl%0d_latency", i), n, LAT);
                check($sformatf("tbl%0d_y0", i), out_y(0), v.y0);
                check($sformatf("tbl%0d_y1", i), out_y(1), v.y1);
                check($sformatf("tbl%0d_ovf", i), int'(bus.m_ovf), int'(v.ovf));
            end
        end
        repeat (4) tick();

        // backpressure: m_ready follows 1,0,0,1 per cycle while six single-tile beats stream
        pat      = '{1'b1, 1'b0, 1'b0, 1'b1};
        start    = delivered;
        sent     = 0;
        cyc      = 0;
        n        = 0;
        need_new = 1'b1;
        while ((sent < 6 || delivered - start < 6) && n < 200) begin
            bus.m_ready = pat[cyc % 4];
            cyc++;
            if (sent < 6) begin
                if (need_new) begin
                    bus.s_k = 12'($urandom());
                    bus.s_x = 6'($urandom());
                end
                bus.s_last  = 1'b1;
                bus.s_relu  = 1'($urandom());
                bus.s_valid = 1'b1;
            end else begin
                bus.s_valid = 1'b0;
            end
            @(negedge clk);
            need_new = bus.s_valid && bus.s_ready;
            if (need_new) sent++;
            tick();
            n++;
        end
        bus.s_valid = 1'b0;
        bus.m_ready = 1'b1;
        check("bp_beats_sent", sent, 6);
        check("bp_results_delivered", delivered - start, 6);
        check("bp_queue_empty", exp_q.size(), 0);
        repeat (2) tick();

        // async reset mid-vector with a result held under backpressure
        send_beat(1, 1, 1, 1, 3, 1, 1'b1, 1'b0);
        send_beat(1, 1, 1, 1, 2, 2, 1'b0, 1'b0);
        bus.m_ready = 1'b0;
        wait_result(n);
        check("pre_rst_m_valid", int'(bus.m_valid), 1);
        #2;
        rstn = 1'b0;
        #1;
        check("midrst_m_valid", int'(bus.m_valid), 0);
        check("midrst_s_ready", int'(bus.s_ready), 0);
        check("midrst_m_y", int'(bus.m_y), 0);
        tick();
        tick();
        #3;
        rstn = 1'b1;
        bus.m_ready = 1'b1;
        tick();
        send_beat(1, 2, 3, -4, 2, -1, 1'b1, 1'b0);
        wait_result(n);
        check("post_rst_latency", n, LAT);
        check("post_rst_y0", out_y(0), 0);
        check("post_rst_y1", out_y(1), 10);
        check("post_rst_ovf", int'(bus.m_ovf), 0);
        repeat (3) tick();

        // random traffic against the scoreboard
        for (int i = 0; i < 600; i++) begin
            bus.s_valid = ($urandom_range(0, 3) != 0);
            bus.s_k     = 12'($urandom());
            bus.s_x     = 6'($urandom());
            bus.s_last  = ($urandom_range(0, 2) == 0);
            bus.s_relu  = 1'($urandom());
            bus.m_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        bus.s_valid = 1'b0;
        bus.m_ready = 1'b1;
        n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            tick();
            n++;
        end
        tick();
        check("final_queue_empty", exp_q.size(), 0);
        check("final_m_valid", int'(bus.m_valid), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
